// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution datapath blocks.
// Holds the multiplier operand width, default requester count and counter width.
package conv_pkg;
    localparam int DW        = 8;
    localparam int N_REQ_DEF = 4;
    localparam int CNT_W     = 16;

    typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;
endpackage

// File: rtl/multu8.sv
// Unsigned 8x8 multiplier keeping the low 8 bits of the product.
// Purely combinational; no flow control.
module multu8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);
    assign o_p = i_a * i_b;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after `last`.
// Combinational, zero latency; grants nothing while en is low.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx
);
    logic [IDW-1:0] w_cand [N_REQ];
    logic           w_found;

    // w_cand[k] is the requester at priority rank k (last+1 is rank 0).
    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
        assign w_cand[k] = IDW'((int'(last) + k + 1) % N_REQ);
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (en && !w_found && req[w_cand[k]]) begin
                gnt[w_cand[k]] = 1'b1;
                gnt_idx        = w_cand[k];
                w_found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/multu8_sched.sv
// Round-robin time-sharing of one multu8 among N_REQ requesters; 2-cycle latency, 1 op/cycle.
// No response backpressure: rsp_valid pulses must be consumed every cycle.
module multu8_sched #(
    parameter int N_REQ = conv_pkg::N_REQ_DEF,
    parameter int DW    = conv_pkg::DW,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DW-1:0]        a_in,
    input  logic [N_REQ*DW-1:0]        b_in,
    output logic [N_REQ-1:0]           gnt,
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [DW-1:0]              rsp_data,
    output logic [conv_pkg::CNT_W-1:0] op_count
);
    import conv_pkg::*;

    logic [DW-1:0]    w_a [N_REQ];
    logic [DW-1:0]    w_b [N_REQ];
    logic [N_REQ-1:0] w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_xfer;
    logic [DW-1:0]    w_prod;

    logic [IDW-1:0]   r_last;
    logic             r_s1_vld;
    logic [IDW-1:0]   r_s1_id;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic             r_rsp_vld;
    logic [IDW-1:0]   r_rsp_id;
    logic [DW-1:0]    r_rsp_data;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_a[i] = a_in[i*DW +: DW];
        assign w_b[i] = b_in[i*DW +: DW];
    end

    // Reset also masks grants so nothing looks granted while rst_n is low.
    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req     (req),
        .last    (r_last),
        .en      (en & rst_n),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_xfer = |w_gnt;

    multu8 u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= IDW'(N_REQ - 1);
            r_s1_vld   <= 1'b0;
            r_s1_id    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
            r_cnt      <= '0;
        end else begin
            r_s1_vld  <= w_xfer;
            r_rsp_vld <= r_s1_vld;
            if (w_xfer) begin
                r_last  <= w_gnt_idx;
                r_s1_id <= w_gnt_idx;
                r_a     <= w_a[w_gnt_idx];
                r_b     <= w_b[w_gnt_idx];
            end
            // Response fields only move on a valid op so rsp_data holds between pulses.
            if (r_s1_vld) begin
                r_rsp_id   <= r_s1_id;
                r_rsp_data <= w_prod;
                r_cnt      <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign gnt       = w_gnt;
    assign rsp_valid = r_rsp_vld;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign op_count  = r_cnt;
endmodule

// File: doc/multu8_sched.md
# multu8_sched

Round-robin scheduler that time-shares one `multu8` unsigned 8-bit multiplier among `N_REQ` requesters, such as systolic-array PEs or a bias/scale stage. It accepts one multiply per cycle. Each accepted multiply passes through a two-register pipeline: operand capture, then result capture. The result returns tagged with the requester ID. The block sits between the convolution PE array and the shared multiplier resource.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, at least 2.
- `DW`, 8: operand and result width. Fixed by `multu8`.
- `IDW`, `$clog2(N_REQ)`: requester ID width.

Ports:
- `clk` in, 1: the single clock. All state changes on the rising edge.
- `rst_n` in, 1: reset. **Asynchronous, active-low.**
- `en` in, 1: grant enable. When low, no new grants; in-flight work still completes.
- `req` in, N_REQ: per-requester request, level-sensitive.
- `a_in` in, N_REQ*DW: packed operand A; requester i uses bits `[i*DW +: DW]`.
- `b_in` in, N_REQ*DW: packed operand B, packed the same way.
- `gnt` out, N_REQ: one-hot grant, combinational, same cycle as `req`.
- `rsp_valid` out, 1: one-cycle pulse when `rsp_data` is valid.
- `rsp_id` out, IDW: index of the requester that owns `rsp_data`.
- `rsp_data` out, DW: product `(a*b) mod 256`, i.e. the `multu8` output.
- `op_count` out, 16: number of completed multiplies, wrapping.

## Operation
- **Arbitration:**
  - Pointer `last` holds the index of the last granted requester.
  - Priority order is `last+1, last+2, …` mod `N_REQ`.
  - `gnt` is one-hot for the first requester in that order with `req` high; it is all-zero when `en`=0 or no `req` is set.
- **Transfer:** a transfer happens at a rising edge where `req[i] & gnt[i]`. On that edge:
  - `a_in`/`b_in` slice i is captured into the operand registers.
  - The stage-1 valid bit is set and the ID is registered.
  - `last` is set to i.
- **Requester protocol:**
  - To issue another operation, the requester keeps `req` high and presents new operands in the cycle after its grant.
  - If it does not, it drops `req`.
  - Operands must be stable only in the cycle in which `gnt[i]` is high.
- **Stage 2:**
  - The `multu8` output from the operand registers is registered into `rsp_data`.
  - Stage-1 valid and ID move to `rsp_valid` and `rsp_id`.
  - `op_count` increments by 1 when the stage-1 valid bit is set, wrapping from 0xFFFF to 0.
- **Enable:** `en` gates only new grants. Dropping `en` never cancels or stalls the pipeline.
- There is no backpressure on the response side. Consumers must accept `rsp_valid` unconditionally.

## Timing
- Transfer at edge k causes `rsp_valid`=1 with the result during the cycle after edge k+1, i.e. 2-cycle latency.
- Throughput is 1 op per cycle. With continuous requests, `rsp_valid` stays high every cycle.
- A single persistent requester receives a grant every cycle, since no other requester competes.
- With all requesters active, grants rotate `0,1,2,3,0,…` starting from reset.
- **Reset values** (asynchronous, while `rst_n`=0):
  - `last`=`N_REQ-1`, so requester 0 has top priority after reset.
  - Stage valids, `rsp_valid`, `rsp_id`, `rsp_data` = 0; `op_count` = 0.
  - `gnt` = 0 while `rst_n` is low.
- Reset mid-operation: in-flight operations are discarded with no `rsp_valid`, and `op_count` is not incremented for them.
- A `req` that drops in the same cycle it would have been granted produces no transfer and no `last` update.
- `rsp_data` holds its last value when `rsp_valid`=0, except after reset.

## Structure
- Shared package `conv_pkg`: `DW`=8, default `N_REQ`, the `op_count` width constant, and a `req_id_t` typedef.
- Sub-module `rr_arbiter`: inputs `req`, `last`, `en`; output one-hot `gnt` and encoded index. Purely combinational.
- `multu8` is instantiated unmodified between the stage-1 and stage-2 registers.
- `multu8_sched` holds the pointer, the pipeline registers and the counter.

## Test plan
- **Reset then single request:** reset, then `req`=0001 with A0=5, B0=7 for one cycle.
  - `gnt`=0001; 2 cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_data`=35; `op_count`=1.
- **Wrap of product:** requester 2 with A=20, B=20 → `rsp_data`=144 (400 mod 256), `rsp_id`=2.
  - A=255, B=255 → `rsp_data`=1.
- **All requesting, fairness:** `req`=1111 held for 8 cycles.
  - Grant sequence 0,1,2,3,0,1,2,3; `rsp_valid` high for 8 consecutive cycles; `op_count`=8.
- **Enable gating:** `req`=1111 with `en` dropped after 2 grants, for 3 cycles.
  - No grants during those 3 cycles; both in-flight results still emerge.
  - On re-enable, the next grant goes to requester 2.
- **Async reset mid-flight:** pulse `rst_n` low between transfer and response, off any clock edge.
  - All outputs go to 0 immediately; no `rsp_valid` afterwards; `op_count`=0.
- **Counter wrap:** preload by running 65536 ops (or force) → `op_count` returns to 0 on the 65536th completion.
